// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: runs one ADC record capture through the sample FIFO.
// Sequence: flush the FIFO, let the front end settle, gate a programmed
// number of writes, then drain the FIFO into a valid/ready output stream.
// All logic is in the clk domain; write-side retiming lives in the top level.
module adc_capture_ctrl #(
  parameter int PRECISION        = 10,
  parameter int FIFO_COUNT_WIDTH = 12,
  parameter int RST_CYCLES       = 8,
  parameter int SETTLE_CYCLES    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [FIFO_COUNT_WIDTH-1:0] i_num_samples,
  input  logic                        i_sample_strobe,
  input  logic                        i_fifo_full,
  input  logic                        i_fifo_empty,
  input  logic [PRECISION-1:0]        i_fifo_dout,
  output logic                        o_fifo_rst,
  output logic                        o_fifo_wr_en,
  output logic                        o_fifo_rd_en,
  output logic [PRECISION-1:0]        o_out_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overflow
);

  // One timer serves both FLUSH and SETTLE, so size it for the longer one.
  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [TW-1:0]               r_tmr;
  logic [FIFO_COUNT_WIDTH-1:0] r_num;       // record length, shrinks on overflow
  logic [FIFO_COUNT_WIDTH-1:0] r_wr_cnt;    // samples written (strobes seen)
  logic [FIFO_COUNT_WIDTH-1:0] r_rd_cnt;    // samples loaded into the output reg
  logic [FIFO_COUNT_WIDTH-1:0] r_rd_iss;    // FIFO reads issued
  logic [FIFO_COUNT_WIDTH-1:0] w_wr_cnt_nxt;
  logic                        r_rd_pend;   // FIFO read data arrives this cycle
  logic                        r_out_valid;
  logic [PRECISION-1:0]        r_out_data;
  logic                        r_overflow;
  logic                        w_start_acc;
  logic                        w_wr_last;

  // Count including a strobe in this cycle, so the write gate can close on
  // the very strobe that completes the record.
  assign w_wr_cnt_nxt = r_wr_cnt + FIFO_COUNT_WIDTH'(i_sample_strobe);
  assign w_wr_last    = i_sample_strobe && (w_wr_cnt_nxt == r_num);
  assign w_start_acc  = (r_state == S_IDLE) && i_start && !i_abort;

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overflow  = r_overflow;

  // Next-state and decoded outputs; abort overrides every transition.
  always_comb begin
    w_state_nxt  = r_state;
    o_fifo_rst   = 1'b0;
    o_fifo_wr_en = 1'b0;
    o_fifo_rd_en = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_start_acc) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        o_fifo_rst = 1'b1;
        if (r_tmr == RST_LAST) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_tmr == SETTLE_LAST)
          w_state_nxt = (r_num == '0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        o_fifo_wr_en = !w_wr_last && !i_fifo_full;
        if (w_wr_last || i_fifo_full) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // One read in flight at a time; only read when the output reg frees.
        o_fifo_rd_en = !i_fifo_empty && (r_rd_iss < r_num) && !r_rd_pend &&
                       (!r_out_valid || i_out_ready);
        if ((r_rd_cnt == r_num) && !r_out_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Flush/settle timer: restarts on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                        r_tmr <= '0;
    else if (w_state_nxt != r_state)                     r_tmr <= '0;
    else if ((r_state == S_FLUSH) || (r_state == S_SETTLE)) r_tmr <= r_tmr + TW'(1);
  end

  // Counters, read pipeline, output register and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num       <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_iss    <= '0;
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else if (i_abort) begin
      // Drop anything in flight; overflow is kept for the host to read.
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_num       <= i_num_samples;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_iss    <= '0;
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_rd_pend <= o_fifo_rd_en;
      if (o_fifo_rd_en) r_rd_iss <= r_rd_iss + FIFO_COUNT_WIDTH'(1);
      // A load takes priority over a simultaneous accept.
      if (r_rd_pend) begin
        r_out_data  <= i_fifo_dout;
        r_out_valid <= 1'b1;
        r_rd_cnt    <= r_rd_cnt + FIFO_COUNT_WIDTH'(1);
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == S_CAPTURE) begin
        r_wr_cnt <= w_wr_cnt_nxt;
        // FIFO filled early: truncate the record to what was written.
        if (i_fifo_full) begin
          r_overflow <= 1'b1;
          r_num      <= w_wr_cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scenarios with a scoreboard of expected
// output beats; a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
  localparam int PW = 10;
  localparam int CW = 12;
  localparam int RC = 8;
  localparam int SC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num = '0;
  logic          strobe = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [PW-1:0] fifo_dout = '0;
  logic          out_ready = 1'b1;
  logic          fifo_rst, wr_en, rd_en, out_valid, busy, done, overflow;
  logic [PW-1:0] out_data;
  logic [PW-1:0] sdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_capture_ctrl #(
    .PRECISION(PW), .FIFO_COUNT_WIDTH(CW), .RST_CYCLES(RC), .SETTLE_CYCLES(SC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_num_samples(num), .i_sample_strobe(strobe), .i_fifo_full(fifo_full),
    .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout),
    .o_fifo_rst(fifo_rst), .o_fifo_wr_en(wr_en), .o_fifo_rd_en(rd_en),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Environment FIFO: a strobe means a sample landed in the FIFO.
  logic [PW-1:0] fq[$];
  always @(posedge clk) begin
    if (fifo_rst) fq.delete();
    else begin
      if (rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (strobe) fq.push_back(sdata);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard and protocol monitor.
  logic [PW-1:0] exp_q[$];
  int rx_cnt = 0, done_cnt = 0, rst_hi = 0, wr_mon = 0, rd_mon = 0;
  int hold_viol = 0, bp_viol = 0, busy_viol = 0;
  logic pv_stall = 1'b0, pdone = 1'b0;
  logic [PW-1:0] pdata = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: got data %0h with no beat expected", out_data);
        end else check("beat_data", out_data, exp_q.pop_front());
        rx_cnt++;
      end
      if (pv_stall && (!out_valid || out_data !== pdata)) hold_viol++;
      if (rd_en && out_valid && !out_ready) bp_viol++;
      if (fifo_rst) rst_hi++;
      if (wr_en) wr_mon++;
      if (rd_en) rd_mon++;
      if (done) begin done_cnt++; if (!busy) busy_viol++; end
      if (pdone && busy) busy_viol++;
      pv_stall = out_valid && !out_ready;
      pdata = out_data;
      pdone = done;
    end else begin
      pv_stall = 1'b0;
      pdone = 1'b0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic nedge(); @(negedge clk); #1; endtask

  task automatic do_start(input int n);
    num = CW'(n); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    nedge();
    while (!wr_en && n < 200) begin n++; nedge(); end
    if (!wr_en) begin checks++; failures++; $display("FAIL wait_wr: wr_en never rose, got 0 expected 1"); end
  endtask

  task automatic send_strobes(input int n, input logic [PW-1:0] base, input bit chk_drop);
    for (int k = 0; k < n; k++) begin
      logic [PW-1:0] v;
      v = base + PW'(k);
      @(posedge clk); #1;
      strobe = 1'b1; sdata = v; exp_q.push_back(v);
      @(negedge clk);
      check("wr_en_during_strobe", wr_en, (chk_drop && k == n - 1) ? 0 : 1);
      @(posedge clk); #1;
      strobe = 1'b0;
    end
  endtask

  task automatic wait_rx(input int target);
    int k = 0;
    while (rx_cnt < target && k < 500) begin nedge(); k++; end
    if (rx_cnt < target) begin checks++; failures++; $display("FAIL wait_rx: got %0d beats expected %0d", rx_cnt, target); end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    nedge();
    while (busy && k < 3000) begin nedge(); k++; end
    if (busy) begin checks++; failures++; $display("FAIL %s: timeout busy got 1 expected 0", nm); end
    nedge();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, d0, x0, w0, q0;
    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset_outs", {fifo_rst, wr_en, rd_en, out_valid, busy, done, overflow, out_data}, 0);
    rst_n = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins
    num = 12'd5; start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    nedge();
    check("start_abort_idle", busy, 0);

    // Nominal record of 5
    r0 = rst_hi; d0 = done_cnt; x0 = rx_cnt;
    do_start(5);
    wait_wr(n);
    check("flush_settle_lat", n, RC + SC);
    send_strobes(5, 10'h100, 1'b1);
    wait_idle("nominal_idle");
    check("nominal_rst_cycles", rst_hi - r0, RC);
    check("nominal_beats", rx_cnt - x0, 5);
    check("nominal_done", done_cnt - d0, 1);
    check("nominal_sb_empty", exp_q.size(), 0);
    check("nominal_overflow", overflow, 0);

    // Backpressure: out_ready low 10 cycles mid-drain
    d0 = done_cnt; x0 = rx_cnt;
    do_start(6);
    wait_wr(n);
    send_strobes(6, 10'h155, 1'b1);
    wait_rx(x0 + 1);
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (10) tick();
    out_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_beats", rx_cnt - x0, 6);
    check("bp_hold_stable", hold_viol, 0);
    check("bp_no_rd_when_stalled", bp_viol, 0);
    check("bp_done", done_cnt - d0, 1);

    // Overflow: 40 of 100 then fifo_full
    d0 = done_cnt; x0 = rx_cnt;
    do_start(100);
    wait_wr(n);
    send_strobes(40, 10'h200, 1'b0);
    @(posedge clk); #1; fifo_full = 1'b1;
    @(negedge clk);
    check("ovf_wr_en_drop", wr_en, 0);
    tick();
    fifo_full = 1'b0;
    check("ovf_flag_set", overflow, 1);
    wait_idle("ovf_idle");
    check("ovf_beats", rx_cnt - x0, 40);
    check("ovf_done", done_cnt - d0, 1);
    check("ovf_sticky", overflow, 1);
    check("ovf_sb_empty", exp_q.size(), 0);

    // Zero length; start also clears overflow
    d0 = done_cnt; r0 = rst_hi; w0 = wr_mon; q0 = rd_mon;
    do_start(0);
    nedge();
    check("zero_ovf_cleared", overflow, 0);
    wait_idle("zero_idle");
    check("zero_no_wr", wr_mon - w0, 0);
    check("zero_no_rd", rd_mon - q0, 0);
    check("zero_done", done_cnt - d0, 1);
    check("zero_rst_cycles", rst_hi - r0, RC);

    // Abort mid-drain after 2 of 5
    d0 = done_cnt; x0 = rx_cnt;
    do_start(5);
    wait_wr(n);
    send_strobes(5, 10'h300, 1'b1);
    wait_rx(x0 + 2);
    @(posedge clk); #1; abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_outs", {busy, wr_en, rd_en, out_valid, done, fifo_rst}, 0);
    exp_q.delete();
    repeat (20) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_beats", rx_cnt - x0, 2);
    // Restart re-flushes and runs a clean record
    r0 = rst_hi; d0 = done_cnt; x0 = rx_cnt;
    do_start(3);
    wait_wr(n);
    check("restart_lat", n, RC + SC);
    send_strobes(3, 10'h340, 1'b1);
    wait_idle("restart_idle");
    check("restart_rst_cycles", rst_hi - r0, RC);
    check("restart_beats", rx_cnt - x0, 3);
    check("restart_done", done_cnt - d0, 1);

    // Async reset mid-capture, no clock edge
    do_start(5);
    wait_wr(n);
    send_strobes(2, 10'h3a0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {busy, wr_en, fifo_rst, rd_en, out_valid, done, overflow}, 0);
    exp_q.delete();
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("start_in_reset", busy, 0);
    start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    nedge();
    check("after_reset_idle", busy, 0);
    // Clean record after reset
    d0 = done_cnt; x0 = rx_cnt;
    do_start(2);
    wait_wr(n);
    check("post_rst_lat", n, RC + SC);
    send_strobes(2, 10'h3c0, 1'b1);
    wait_idle("post_rst_idle");
    check("post_rst_beats", rx_cnt - x0, 2);
    check("post_rst_done", done_cnt - d0, 1);
    check("busy_after_done", busy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences one ADC record capture through the ADC sample FIFO: flush, settle, gated write of a programmed sample count, then drain to a valid/ready output stream. All interfaces are in the clk domain. Write-side signals (fifo_wr_en, sample_strobe) are retimed to/from adc_clk by the surrounding top level. Sits between the FIFO instance and the readout/host logic in ADC_Testing_Top.

Parameters:
PRECISION, 10, ADC code width (FIFO data width)
FIFO_COUNT_WIDTH, 12, width of sample counters and num_samples
RST_CYCLES, 8, cycles fifo_rst is held high during flush (>=1)
SETTLE_CYCLES, 16, idle cycles after flush before writes are enabled (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle capture request; ignored unless idle
abort  in  1  single-cycle abort; returns to idle from any state
num_samples  in  FIFO_COUNT_WIDTH  samples to capture; sampled on accepted start
sample_strobe  in  1  one pulse per sample written into the FIFO
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  PRECISION  FIFO read data, valid the cycle after fifo_rd_en
fifo_rst  out  1  FIFO reset
fifo_wr_en  out  1  write gate
fifo_rd_en  out  1  read strobe
out_data  out  PRECISION  sample stream data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a record completes normally
overflow  out  1  sticky error flag; set if fifo_full while capturing; cleared on accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0, all counters 0.
- States and transitions:
  - IDLE -> FLUSH on start && !abort.
  - FLUSH: fifo_rst=1 for exactly RST_CYCLES cycles, then -> SETTLE.
  - SETTLE: SETTLE_CYCLES cycles, then -> CAPTURE. If latched num_samples==0, go directly to DONE instead.
  - CAPTURE: fifo_wr_en=1. wr_cnt increments on each sample_strobe.
    - When wr_cnt reaches num_samples, fifo_wr_en drops in the same cycle (combinational compare on the next count) and state -> DRAIN.
  - DRAIN -> DONE when rd_cnt == num_samples and out_valid==0.
  - DONE: done=1 for one cycle, then -> IDLE.
- Registered state is updated on the cycle after the strobe.
- fifo_full during CAPTURE: sets overflow, drops fifo_wr_en, and moves to DRAIN with num_samples replaced by the current wr_cnt. The partial record is drained, and done still pulses.
- Read handshake:
  - fifo_rd_en = DRAIN && !fifo_empty && rd_cnt_issued < num_samples && !rd_pend && (!out_valid || out_ready).
  - rd_pend is set for the one cycle after fifo_rd_en.
  - In that cycle fifo_dout is loaded into out_data, out_valid=1, and rd_cnt increments.
  - out_valid holds with out_data stable until out_ready. Maximum throughput is one sample per 2 cycles.
- Simultaneous out_ready and a new load: the load wins and out_valid stays 1.
- abort (any state, highest priority):
  - Next cycle: state IDLE; fifo_wr_en, fifo_rd_en and out_valid cleared; done not pulsed; overflow kept.
  - Any in-flight FIFO data is discarded; the next start flushes the FIFO.
- start while busy is ignored. start and abort together in IDLE: abort wins and the block stays IDLE.
- Counters are FIFO_COUNT_WIDTH wide and never wrap, because num_samples bounds them.

Test Plan:
- Nominal: num_samples=5, RST_CYCLES=8, SETTLE_CYCLES=16, 5 strobes, out_ready=1.
  - fifo_rst high exactly 8 cycles; fifo_wr_en rises 16 cycles later and falls on the 5th strobe.
  - 5 out_valid beats in FIFO order; done pulses once; busy falls the cycle after done.
- Backpressure: out_ready low 10 cycles during DRAIN.
  - out_data/out_valid held stable; no fifo_rd_en while out_valid && !out_ready; no sample lost or duplicated.
- Overflow: num_samples=100, fifo_full asserted after 40 strobes.
  - overflow=1, fifo_wr_en low that cycle; exactly 40 samples drained; done pulses.
  - overflow stays set until the next start.
- Zero length: num_samples=0 -> flush and settle only; no wr_en or rd_en; done pulses.
- Abort mid-DRAIN after 2 of 5 samples -> next cycle IDLE, all outputs low, no done.
  - A following start re-flushes the FIFO (fifo_rst high 8 cycles).
- Async reset: assert rst_n low mid-CAPTURE without a clock edge -> outputs 0 immediately; start ignored until rst_n is high.
